alu_opb_stage: RTL and testbench
================================

ALU_OPB_STAGE -- requirements
Module: alu_opb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter NSRC, default 4, number of operand-B sources (min 2).
REQ-003 SHALL have parameter SHAMT_IDX, default 2, source index carrying a shift amount.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1  upstream handshake.
REQ-007 SHALL have port sel  input  $clog2(NSRC)  source select.
REQ-008 SHALL have port src  input  NSRC x XLEN  sources; src[0] = rs2 register-file value.
REQ-009 SHALL have ports rs2_idx input 5, word_op input 1 (RV64 *W op), flush input 1.
REQ-010 SHALL have ports fwd_ex_valid 1, fwd_ex_rd 5, fwd_ex_data XLEN, fwd_mem_valid 1, fwd_mem_rd 5, fwd_mem_data XLEN, all inputs.
REQ-011 SHALL have ports out_valid output 1 / out_ready input 1  downstream handshake.
REQ-012 SHALL have ports out_data output XLEN, out_fwd output 2 (fwd_src_e), sel_err output 1.

Function
REQ-013 SHALL compute operand combinationally from inputs on the accepting cycle, then register it.
REQ-014 SHALL, for sel==0, forward fwd_ex_data if fwd_ex_valid and fwd_ex_rd==rs2_idx!=0, else fwd_mem_data under same rule with MEM, else src[0]; EX wins over MEM.
REQ-015 SHALL never forward when rs2_idx==0; out_fwd = FWD_NONE then.
REQ-016 SHALL, for sel==SHAMT_IDX, output src[SHAMT_IDX] zero-extended from low 6 bits, or low 5 bits when word_op=1.
REQ-017 SHALL, for other sel<NSRC, output src[sel] unmodified.
REQ-018 SHALL, for sel>=NSRC, output forwarded src[0] path and set sel_err=1 with that beat.
REQ-019 SHALL accept a beat when in_valid && in_ready; latency accept->out_valid exactly 1 cycle when empty.
REQ-020 SHALL hold out_data/out_fwd/sel_err stable while out_valid && !out_ready.
REQ-021 SHALL use a two-entry skid: states EMPTY, ONE, TWO; in_ready = (state != TWO), registered.
REQ-022 SHALL transition EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE stays on simultaneous accept+drain; TWO->ONE on drain (no accept possible).
REQ-023 SHALL preserve beat order; skid entry moves to output on the drain cycle in TWO.
REQ-024 SHALL, on flush=1, go to EMPTY next cycle, discard both entries and drop any beat offered that cycle.
REQ-025 SHALL sustain one beat per cycle when out_ready held 1.

Reset
REQ-026 SHALL on rst_n low, asynchronously, set state EMPTY, out_valid 0, out_data 0, out_fwd FWD_NONE, sel_err 0.
REQ-027 SHALL drive in_ready 1 from first clock edge after rst_n deasserts.
REQ-028 SHALL discard in-flight beats on reset mid-operation; no beat emerges afterwards.

Structure
REQ-029 SHALL place fwd_src_e (FWD_NONE, FWD_EX, FWD_MEM), skid state enum, SHAMT_W64=6, SHAMT_W32=5 in shared package alu_pkg.
REQ-030 SHALL instantiate one sub-module, skid_buf, parametrised on payload width, holding the handshake/state logic; operand selection stays in alu_opb_stage.

Verification
REQ-031 SHALL test forwarding: rs2_idx=5, EX rd=5 data=0xAA, MEM rd=5 data=0xBB, sel=0 -> out_data=0xAA, out_fwd=FWD_EX; then EX invalid -> 0xBB, FWD_MEM.
REQ-032 SHALL test x0: rs2_idx=0, EX rd=0 valid, src[0]=0x7 -> out_data=0x7, FWD_NONE.
REQ-033 SHALL test shamt: sel=2, src[2]=0xFFFF_FFFF_FFFF_FFE3, word_op=0 -> 0x23; word_op=1 -> 0x03.
REQ-034 SHALL test backpressure: out_ready=0, push beats 1,2 -> in_ready=0 after second; beat 3 held; release -> outputs 1,2,3 in order, no loss/dup.
REQ-035 SHALL test sel_err and flush: NSRC=3, sel=3 -> src[0] path, sel_err=1; flush in TWO -> out_valid=0 next cycle, in_ready=1.
REQ-036 SHALL test async reset mid-stream: rst_n low between edges in state TWO -> out_valid=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand-B stage.
package alu_pkg;

    // Where operand B came from on a given beat.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2
    } fwd_src_e;

    // Occupancy of the two-entry output skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Shift-amount widths for RV64 full-width and *W operations.
    localparam int SHAMT_W64 = 6;
    localparam int SHAMT_W32 = 5;

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer: a head register that drives the output and one
// skid register that catches the beat accepted while the head is stalled.
// in_ready is registered and derived from the next occupancy.
module skid_buf
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         drain;

    // A beat offered during flush is dropped, so it never counts as accepted.
    assign accept    = in_valid && in_ready_q && !flush;
    assign out_valid = (state_q != SKID_EMPTY);
    assign drain     = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_data  = head_q;

    // Next occupancy and register contents; the skid entry moves to the head when TWO drains.
    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        head_d  = in_data;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        head_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = SKID_TWO;
                    end else if (drain) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low in TWO, so only a drain can happen here.
                    if (drain) begin
                        head_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        in_ready_d = (state_d != SKID_TWO);
    end

    // State and payload registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            // NOTE: the payload registers are reset because head_q is visible on out_data and must read zero during reset.
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/alu_opb_stage.sv
// ALU operand-B select stage: picks operand B from the source bus (with
// EX/MEM forwarding on the rs2 path and shift-amount masking), then
// registers it through a two-entry skid buffer.
module alu_opb_stage
    import alu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NSRC      = 4,
    parameter int SHAMT_IDX = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [$clog2(NSRC)-1:0]       sel,
    input  logic [NSRC-1:0][XLEN-1:0]     src,
    input  logic [4:0]                    rs2_idx,
    input  logic                          word_op,
    input  logic                          flush,
    input  logic                          fwd_ex_valid,
    input  logic [4:0]                    fwd_ex_rd,
    input  logic [XLEN-1:0]               fwd_ex_data,
    input  logic                          fwd_mem_valid,
    input  logic [4:0]                    fwd_mem_rd,
    input  logic [XLEN-1:0]               fwd_mem_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_data,
    output logic [1:0]                    out_fwd,
    output logic                          sel_err
);

    localparam int PAY_W = XLEN + 3;

    logic [31:0]     sel_ext;
    logic            ex_hit;
    logic            mem_hit;
    logic [XLEN-1:0] rs2_data;
    fwd_src_e        rs2_fwd;
    logic [XLEN-1:0] sel_src;
    logic [XLEN-1:0] op_data;
    fwd_src_e        op_fwd;
    logic            op_err;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign sel_ext = 32'(sel);

    // rs2 forwarding: EX beats MEM, and x0 is never forwarded.
    always_comb begin
        ex_hit   = fwd_ex_valid  && (fwd_ex_rd  == rs2_idx) && (rs2_idx != 5'd0);
        mem_hit  = fwd_mem_valid && (fwd_mem_rd == rs2_idx) && (rs2_idx != 5'd0);
        rs2_data = src[0];
        rs2_fwd  = FWD_NONE;
        if (ex_hit) begin
            rs2_data = fwd_ex_data;
            rs2_fwd  = FWD_EX;
        end else if (mem_hit) begin
            rs2_data = fwd_mem_data;
            rs2_fwd  = FWD_MEM;
        end
    end

    // Operand select; an out-of-range sel falls back to the rs2 path and flags the beat.
    always_comb begin
        sel_src = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_ext == 32'(i)) sel_src = src[i];
        end
        op_data = sel_src;
        op_fwd  = FWD_NONE;
        op_err  = 1'b0;
        if (sel_ext == 32'd0 || sel_ext >= 32'(NSRC)) begin
            op_data = rs2_data;
            op_fwd  = rs2_fwd;
            op_err  = (sel_ext >= 32'(NSRC));
        end else if (sel_ext == 32'(SHAMT_IDX)) begin
            op_data = word_op ? XLEN'(src[SHAMT_IDX][SHAMT_W32-1:0])
                              : XLEN'(src[SHAMT_IDX][SHAMT_W64-1:0]);
        end
    end

    assign pay_in = {op_err, op_fwd, op_data};

    skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign out_data = pay_out[XLEN-1:0];
    assign out_fwd  = pay_out[XLEN+1:XLEN];
    assign sel_err  = pay_out[XLEN+2];

endmodule

// File: tb/tb_alu_opb_stage.sv
// Directed bench for alu_opb_stage built with NSRC=3 so that sel=3 is an
// out-of-range select. Inputs change 1 ns after a rising edge and outputs
// are sampled at that same point, away from the edge.
module tb_alu_opb_stage;
    import alu_pkg::*;

    localparam int XLEN = 64;
    localparam int NSRC = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                sel;
    logic [NSRC-1:0][XLEN-1:0] src;
    logic [4:0]                rs2_idx;
    logic                      word_op;
    logic                      flush;
    logic                      fwd_ex_valid;
    logic [4:0]                fwd_ex_rd;
    logic [XLEN-1:0]           fwd_ex_data;
    logic                      fwd_mem_valid;
    logic [4:0]                fwd_mem_rd;
    logic [XLEN-1:0]           fwd_mem_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_data;
    logic [1:0]                out_fwd;
    logic                      sel_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_opb_stage #(
        .XLEN(XLEN),
        .NSRC(NSRC),
        .SHAMT_IDX(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sel          (sel),
        .src          (src),
        .rs2_idx      (rs2_idx),
        .word_op      (word_op),
        .flush        (flush),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_mem_valid(fwd_mem_valid),
        .fwd_mem_rd   (fwd_mem_rd),
        .fwd_mem_data (fwd_mem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_fwd      (out_fwd),
        .sel_err      (sel_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output check of one beat at the head.
    task automatic check_beat(input string tag, input logic [63:0] data, input logic [1:0] fwd,
                              input logic err);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"},  out_data,        data);
        check({tag, ".fwd"},   64'(out_fwd),    64'(fwd));
        check({tag, ".err"},   64'(sel_err),    64'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        sel           = 2'd0;
        src           = '0;
        rs2_idx       = 5'd0;
        word_op       = 1'b0;
        flush         = 1'b0;
        fwd_ex_valid  = 1'b0;
        fwd_ex_rd     = 5'd0;
        fwd_ex_data   = '0;
        fwd_mem_valid = 1'b0;
        fwd_mem_rd    = 5'd0;
        fwd_mem_data  = '0;
        out_ready     = 1'b0;

        // Reset values while rst_n is low.
        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data",  out_data,        64'd0);
        check("rst.fwd",   64'(out_fwd),    64'(FWD_NONE));
        check("rst.err",   64'(sel_err),    64'd0);
        rst_n = 1'b1;
        step();
        check("rst.in_ready_after_edge", 64'(in_ready), 64'd1);
        check("rst.valid_after_edge",    64'(out_valid), 64'd0);

        // Forwarding: EX wins over MEM, one-cycle latency from accept.
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        sel           = 2'd0;
        rs2_idx       = 5'd5;
        src[0]        = 64'h11;
        fwd_ex_valid  = 1'b1;
        fwd_ex_rd     = 5'd5;
        fwd_ex_data   = 64'hAA;
        fwd_mem_valid = 1'b1;
        fwd_mem_rd    = 5'd5;
        fwd_mem_data  = 64'hBB;
        step();
        check_beat("fwd_ex", 64'hAA, FWD_EX, 1'b0);

        fwd_ex_valid = 1'b0;
        step();
        check_beat("fwd_mem", 64'hBB, FWD_MEM, 1'b0);

        // Register x0 is never forwarded.
        rs2_idx       = 5'd0;
        fwd_ex_valid  = 1'b1;
        fwd_ex_rd     = 5'd0;
        fwd_mem_rd    = 5'd0;
        src[0]        = 64'h7;
        step();
        check_beat("x0", 64'h7, FWD_NONE, 1'b0);

        // Shift amount: low 6 bits, or low 5 bits for *W ops.
        fwd_ex_valid  = 1'b0;
        fwd_mem_valid = 1'b0;
        sel           = 2'd2;
        src[2]        = 64'hFFFF_FFFF_FFFF_FFE3;
        word_op       = 1'b0;
        step();
        check_beat("shamt64", 64'h23, FWD_NONE, 1'b0);
        word_op = 1'b1;
        step();
        check_beat("shamt32", 64'h03, FWD_NONE, 1'b0);

        // Plain source passes through unmodified.
        word_op = 1'b0;
        sel     = 2'd1;
        src[1]  = 64'hDEAD_BEEF_1234_5678;
        step();
        check_beat("plain", 64'hDEAD_BEEF_1234_5678, FWD_NONE, 1'b0);

        // Out-of-range select takes the forwarded rs2 path and flags the beat.
        sel          = 2'd3;
        rs2_idx      = 5'd5;
        fwd_ex_valid = 1'b1;
        fwd_ex_rd    = 5'd5;
        fwd_ex_data  = 64'hAA;
        step();
        check_beat("sel_err", 64'hAA, FWD_EX, 1'b1);

        // Drain with nothing offered.
        fwd_ex_valid = 1'b0;
        in_valid     = 1'b0;
        step();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: two beats fill the skid, the third waits.
        sel       = 2'd1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        src[1]    = 64'd1;
        step();
        check_beat("bp.one", 64'd1, FWD_NONE, 1'b0);
        check("bp.one_ready", 64'(in_ready), 64'd1);
        src[1] = 64'd2;
        step();
        check("bp.two_ready", 64'(in_ready), 64'd0);
        check("bp.two_head",  out_data,       64'd1);
        src[1] = 64'd3;
        step();
        check("bp.hold_head",  out_data,       64'd1);
        check("bp.hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check_beat("bp.out2", 64'd2, FWD_NONE, 1'b0);
        check("bp.reopen", 64'(in_ready), 64'd1);
        step();
        check_beat("bp.out3", 64'd3, FWD_NONE, 1'b0);
        in_valid = 1'b0;
        step();
        check("bp.empty", 64'(out_valid), 64'd0);

        // Flush in TWO discards both entries and the offered beat.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        src[1]    = 64'h10;
        step();
        src[1] = 64'h20;
        step();
        check("fl.two_ready", 64'(in_ready), 64'd0);
        src[1] = 64'h30;
        flush  = 1'b1;
        step();
        check("fl.valid", 64'(out_valid), 64'd0);
        check("fl.ready", 64'(in_ready),  64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl.nothing_after", 64'(out_valid), 64'd0);

        // Flush while empty drops a beat offered in the same cycle.
        in_valid = 1'b1;
        src[1]   = 64'h44;
        flush    = 1'b1;
        step();
        check("fl.drop_offer", 64'(out_valid), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset between edges while in TWO.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        rs2_idx   = 5'd9;
        src[0]    = 64'h40;
        step();
        src[0] = 64'h50;
        step();
        check("ar.two_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 64'(out_valid), 64'd0);
        check("ar.data",  out_data,        64'd0);
        check("ar.fwd",   64'(out_fwd),    64'(FWD_NONE));
        check("ar.err",   64'(sel_err),    64'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar.ready_after", 64'(in_ready),  64'd1);
        check("ar.no_beat1",    64'(out_valid), 64'd0);
        step();
        check("ar.no_beat2",    64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
